req_grant_sched: RTL and testbench

- Upstream stage feeding the 4-to-2 priority encoder.
- Captures rising edges on four request lines into sticky pending bits.
- Issues one one-hot grant at a time on y3..y0 and holds it until the consumer acknowledges or a timeout expires.
- Fixed priority y3 > y2 > y1 > y0, matching the downstream encoder, so the encoded code always identifies exactly one served request.

---
 rtl/req_grant_sched_pkg.sv | 9 +
 rtl/req_grant_sched_edge_sync.sv | 24 ++
 rtl/req_grant_sched.sv | 70 +++++++
 tb/tb_req_grant_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_grant_sched_pkg.sv
// req_grant_sched_pkg: shared states, sizes and priority helper for the request/grant scheduler
package req_grant_sched_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int N_REQ = 4;
  localparam int DEF_TIMEOUT = 200;
  function automatic logic [N_REQ-1:0] hi_onehot(input logic [N_REQ-1:0] v);
    return v[3] ? 4'b1000 : v[2] ? 4'b0100 : v[1] ? 4'b0010 : v[0] ? 4'b0001 : 4'b0000;
  endfunction
endpackage

// File: rtl/req_grant_sched_edge_sync.sv
// req_edge_sync: optional 2-flop req synchronizer (REQ_SYNC_EN) plus rising-edge detect; ports clk, rst, req in, rise out
module req_edge_sync
  import req_grant_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] rise
);
  logic [N_REQ-1:0] req_s, req_q;
`ifdef REQ_SYNC_EN
  logic [N_REQ-1:0] s1, s2;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2, s1} <= '0;
    else {s2, s1} <= {s1, req};
  assign req_s = s2;
`else
  assign req_s = req;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) req_q <= '0;
    else req_q <= req_s;
  assign rise = req_s & ~req_q;
endmodule

// File: rtl/req_grant_sched.sv
// req_grant_sched: sticky rising-edge request capture and one-hot fixed-priority grant (y3 > y2 > y1 > y0) held until ack or timeout.
// Ports: clk, rst (async high), req[3:0], ack in; y3..y0, valid, pending[3:0], timeout out. Macro REQ_SYNC_EN adds a 2-flop req synchronizer.
module req_grant_sched
  import req_grant_sched_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic             y3,
  output logic             y2,
  output logic             y1,
  output logic             y0,
  output logic             valid,
  output logic [N_REQ-1:0] pending,
  output logic             timeout
);
  state_t state, state_n;
  logic [N_REQ-1:0] rise, grant, grant_n, pending_n, clr;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic valid_n, tmo_n, expire;
  req_edge_sync u_sync (.clk(clk), .rst(rst), .req(req), .rise(rise));
  assign expire = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  always_comb begin
    state_n = state;
    grant_n = grant;
    valid_n = valid;
    cnt_n   = cnt;
    tmo_n   = 1'b0;
    clr     = '0;
    if (state == IDLE) begin
      if (|pending) begin
        grant_n = hi_onehot(pending);
        valid_n = 1'b1;
        cnt_n   = '0;
        state_n = GRANT;
      end
    end else if (ack || expire) begin
      clr     = grant;
      grant_n = '0;
      valid_n = 1'b0;
      tmo_n   = !ack;
      state_n = IDLE;
    end else begin
      cnt_n = cnt + 1'b1;
    end
    // a fresh rising edge re-pends even the bit being cleared this cycle
    pending_n = (pending & ~clr) | rise;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      valid   <= 1'b0;
      cnt     <= '0;
      timeout <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      valid   <= valid_n;
      cnt     <= cnt_n;
      timeout <= tmo_n;
      pending <= pending_n;
    end
  assign {y3, y2, y1, y0} = grant;
endmodule

// File: tb/tb_req_grant_sched.sv
// tb_req_grant_sched: self-checking bench with a grant scoreboard for req_grant_sched
module tb_req_grant_sched;
`ifdef REQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst = 1, ack = 0, ack0 = 0;
  logic [3:0] req = 0, req0 = 0;
  logic y3, y2, y1, y0, valid, timeout;
  logic z3, z2, z1, z0, valid0, timeout0;
  logic [3:0] pending, pending0, g, g0, e;
  logic [3:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  bit ok;

  req_grant_sched #(.TIMEOUT(200), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .valid(valid), .pending(pending), .timeout(timeout));
  req_grant_sched #(.TIMEOUT(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .ack(ack0), .y3(z3), .y2(z2), .y1(z1), .y0(z0),
    .valid(valid0), .pending(pending0), .timeout(timeout0));

  assign g  = {y3, y2, y1, y0};
  assign g0 = {z3, z2, z1, z0};
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output bit got);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) begin
        got = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pop_check(input string name);
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: grant %b seen, no grant expected", name, g);
    end else begin
      e = exp_q.pop_front();
      if (g !== e || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s: grant %b valid %b, expected %b valid 1", name, g, valid, e);
      end
    end
  endtask

  task automatic test_reset;
    step(1);
    n_chk++;
    if ({g, valid, pending, timeout, g0, valid0} !== '0) begin
      n_fail++;
      $display("FAIL reset: g=%b v=%b p=%b t=%b g0=%b v0=%b, expected all 0", g, valid, pending, timeout, g0, valid0);
    end
    rst = 0;
    step(2);
  endtask

  task automatic test_single;
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    step(1);
    req = 0;
    step(LAT - 2);
    n_chk++;
    if (pending !== 4'b0010 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pend: p=%b v=%b, expected p=0010 v=0", pending, valid);
    end
    step(1);
    pop_check("single_grant");
    step(3);
    n_chk++;
    if (pending !== 4'b0010 || g !== 4'b0010 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold: p=%b g=%b v=%b, expected 0010 0010 1", pending, g, valid);
    end
    ack = 1;
    step(1);
    ack = 0;
    n_chk++;
    if (valid !== 1'b0 || g !== 4'b0000 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_ack: v=%b g=%b p=%b, expected 0 0000 0000", valid, g, pending);
    end
    step(2);
  endtask

  task automatic test_priority;
    req = 4'b0101;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    step(1);
    req = 0;
    wait_valid(ok);
    pop_check("prio_first");
    n_chk++;
    if (!ok || pending !== 4'b0101) begin
      n_fail++;
      $display("FAIL prio_pend1: p=%b ok=%b, expected 0101", pending, ok);
    end
    ack = 1;
    step(1);
    ack = 0;
    n_chk++;
    if (valid !== 1'b0 || pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL prio_idle: v=%b p=%b, expected v=0 p=0001", valid, pending);
    end
    step(1);
    pop_check("prio_second");
    ack = 1;
    step(1);
    ack = 0;
    n_chk++;
    if (valid !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL prio_done: v=%b p=%b, expected v=0 p=0000", valid, pending);
    end
    step(2);
  endtask

  task automatic test_held_level;
    int grants = 0;
    bit prev = 0, acked = 0;
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    for (int i = 0; i < 50; i++) begin
      if (valid && !prev) begin
        grants++;
        pop_check("held_grant");
      end
      prev = valid;
      ack = valid && !acked;
      acked = acked | ack;
      step(1);
    end
    ack = 0;
    n_chk++;
    if (grants != 1 || valid !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL held_once: grants=%0d v=%b p=%b, expected 1 0 0000", grants, valid, pending);
    end
    req = 0;
    step(2);
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    step(1);
    req = 0;
    wait_valid(ok);
    pop_check("held_repend");
    ack = 1;
    step(1);
    ack = 0;
    step(2);
  endtask

  task automatic test_timeout;
    int nv = 0, nt = 0, nt0 = 0;
    req = 4'b0001;
    req0 = 4'b0001;
    exp_q.push_back(4'b0001);
    step(1);
    req = 0;
    req0 = 0;
    wait_valid(ok);
    pop_check("tmo_grant");
    for (int i = 0; i < 210; i++) begin
      nv += int'(valid);
      nt += int'(timeout);
      nt0 += int'(timeout0);
      step(1);
    end
    n_chk++;
    if (nv != 200 || nt != 1 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL tmo_200: valid_cycles=%0d pulses=%0d p=%b, expected 200 1 0000", nv, nt, pending);
    end
    n_chk++;
    if (valid0 !== 1'b1 || g0 !== 4'b0001 || nt0 != 0 || pending0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL tmo_disabled: v0=%b g0=%b pulses=%0d p0=%b, expected 1 0001 0 0001", valid0, g0, nt0, pending0);
    end
    ack0 = 1;
    step(1);
    ack0 = 0;
    n_chk++;
    if (valid0 !== 1'b0 || pending0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL tmo0_ack: v0=%b p0=%b, expected 0 0000", valid0, pending0);
    end
    step(2);
  endtask

  task automatic test_ack_repend;
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    step(1);
    req = 0;
    wait_valid(ok);
    pop_check("repend_grant");
    step(1);
    ack = 1;
    req = 4'b0010;
    step(1);
    ack = 0;
    req = 0;
    step(LAT - 2);
    n_chk++;
    if (valid !== 1'b0 || pending !== 4'b0010) begin
      n_fail++;
      $display("FAIL repend_keep: v=%b p=%b, expected v=0 p=0010", valid, pending);
    end
    step(1);
    pop_check("repend_regrant");
    ack = 1;
    step(1);
    ack = 0;
    step(2);
  endtask

  task automatic test_reset_mid;
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1000);
    wait_valid(ok);
    pop_check("rstmid_grant");
    step(2);
    rst = 1;
    #1;
    n_chk++;
    if (valid !== 1'b0 || g !== 4'b0000 || pending !== 4'b0000 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: v=%b g=%b p=%b t=%b, expected all 0", valid, g, pending, timeout);
    end
    step(1);
    rst = 0;
    step(LAT - 1);
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_early: v=%b, expected 0", valid);
    end
    step(1);
    pop_check("rstmid_regrant");
    ack = 1;
    step(1);
    ack = 0;
    req = 0;
    step(2);
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_held_level;
    test_timeout;
    test_ack_repend;
    test_reset_mid;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d grants outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
